// File: rtl/ssaes_pkg.sv
// Shared constants and enumerations for the SSAES444 S-box scheduler.
package ssaes_pkg;

   localparam int unsigned NW    = 4;
   localparam int unsigned N_ST  = 16;
   localparam int unsigned N_KS  = 4;
   localparam int unsigned ST_W  = N_ST * NW;
   localparam int unsigned KS_W  = N_KS * NW;
   localparam int unsigned CNT_W = $clog2(N_ST);

   typedef enum logic [2:0] {
      IDLE,
      RUN_ST,
      RUN_KS,
      DONE_ST,
      DONE_KS
   } sched_state_t;

   typedef enum logic {
      REQ_ST,
      REQ_KS
   } req_id_t;

endpackage

// File: rtl/ssaes_rr_arb2.sv
// Two-way round-robin arbiter; last_srv advances only when a grant is taken.
module ssaes_rr_arb2
   import ssaes_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_st,
   input  logic req_ks,
   input  logic take,
   output logic gnt_st,
   output logic gnt_ks
);

   req_id_t last_srv_q, last_srv_d;

   always_comb begin
      // On a tie the requester served less recently wins.
      gnt_ks = req_ks & (~req_st | (last_srv_q == REQ_ST));
      gnt_st = req_st & ~gnt_ks;
      last_srv_d = last_srv_q;
      if (take) begin
         last_srv_d = gnt_ks ? REQ_KS : REQ_ST;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_srv_q <= REQ_ST;
      end else begin
         last_srv_q <= last_srv_d;
      end
   end

endmodule

// File: rtl/ssaes_sbox_sched.sv
// Shares one combinational 4-bit S-box between the state and key-schedule paths,
// serialising one nibble per cycle and reassembling the substituted word.
module ssaes_sbox_sched
   import ssaes_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            st_req,
   input  logic [ST_W-1:0] st_in,
   output logic            st_ack,
   output logic [ST_W-1:0] st_out,
   output logic            st_done,
   input  logic            ks_req,
   input  logic [KS_W-1:0] ks_in,
   output logic            ks_ack,
   output logic [KS_W-1:0] ks_out,
   output logic            ks_done,
   output logic [NW-1:0]   sbox_in,
   input  logic [NW-1:0]   sbox_out,
   output logic            busy
);

   sched_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ST_W-1:0] work_q, work_d;
   logic [ST_W-1:0] res_q, res_d;
   logic [ST_W-1:0] st_out_q, st_out_d;
   logic [KS_W-1:0] ks_out_q, ks_out_d;
   logic [ST_W-1:0] res_nxt;
   logic            gnt_st, gnt_ks, take;

   ssaes_rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req_st (st_req),
      .req_ks (ks_req),
      .take   (take),
      .gnt_st (gnt_st),
      .gnt_ks (gnt_ks)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      res_d    = res_q;
      st_out_d = st_out_q;
      ks_out_d = ks_out_q;
      st_ack   = 1'b0;
      ks_ack   = 1'b0;
      st_done  = 1'b0;
      ks_done  = 1'b0;
      sbox_in  = '0;
      take     = 1'b0;
      res_nxt  = res_q;
      res_nxt[NW*32'(cnt_q) +: NW] = sbox_out;

      case (state_q)
         IDLE: begin
            // No grant while reset is held, so acks stay low during reset.
            if (!rst && (gnt_st || gnt_ks)) begin
               take  = 1'b1;
               cnt_d = '0;
               res_d = '0;
               if (gnt_ks) begin
                  ks_ack  = 1'b1;
                  work_d  = {{(ST_W-KS_W){1'b0}}, ks_in};
                  state_d = RUN_KS;
               end else begin
                  st_ack  = 1'b1;
                  work_d  = st_in;
                  state_d = RUN_ST;
               end
            end
         end
         RUN_ST: begin
            sbox_in = work_q[NW*32'(cnt_q) +: NW];
            res_d   = res_nxt;
            if (cnt_q == CNT_W'(N_ST-1)) begin
               st_out_d = res_nxt;
               state_d  = DONE_ST;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN_KS: begin
            sbox_in = work_q[NW*32'(cnt_q) +: NW];
            res_d   = res_nxt;
            if (cnt_q == CNT_W'(N_KS-1)) begin
               ks_out_d = res_nxt[KS_W-1:0];
               state_d  = DONE_KS;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE_ST: begin
            st_done = 1'b1;
            state_d = IDLE;
         end
         DONE_KS: begin
            ks_done = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         work_q   <= '0;
         res_q    <= '0;
         st_out_q <= '0;
         ks_out_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         work_q   <= work_d;
         res_q    <= res_d;
         st_out_q <= st_out_d;
         ks_out_q <= ks_out_d;
      end
   end

   assign st_out = st_out_q;
   assign ks_out = ks_out_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_ssaes_sbox_sched.sv
// Directed and randomized checks of the shared S-box scheduler against a nibble-level model.
module tb_ssaes_sbox_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_req, ks_req;
   logic [63:0] st_in;
   logic [15:0] ks_in;
   logic        st_ack, st_done, ks_ack, ks_done, busy;
   logic [63:0] st_out;
   logic [15:0] ks_out;
   logic [3:0]  sbox_in, sbox_out;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   bit          use_tbl = 1'b0;
   logic [3:0]  tbl [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                             4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
   logic [63:0] exp_st = '0;
   logic [15:0] exp_ks = '0;

   always #5 clk = ~clk;

   always_comb sbox_out = use_tbl ? tbl[sbox_in] : (sbox_in ^ 4'hF);

   ssaes_sbox_sched dut (
      .clk      (clk),
      .rst      (rst),
      .st_req   (st_req),
      .st_in    (st_in),
      .st_ack   (st_ack),
      .st_out   (st_out),
      .st_done  (st_done),
      .ks_req   (ks_req),
      .ks_in    (ks_in),
      .ks_ack   (ks_ack),
      .ks_out   (ks_out),
      .ks_done  (ks_done),
      .sbox_in  (sbox_in),
      .sbox_out (sbox_out),
      .busy     (busy)
   );

   function automatic logic [3:0] sub(input logic [3:0] v);
      return use_tbl ? tbl[v] : ~v;
   endfunction

   function automatic logic [63:0] sub_word(input logic [63:0] d, input int n);
      logic [63:0] r = '0;
      for (int i = 0; i < n; i++) r[4*i +: 4] = sub(d[4*i +: 4]);
      return r;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one job from its accept cycle through the first IDLE cycle after done.
   // raise_at > 0 raises the other requester's req in that RUN cycle; it must stay unacked.
   task automatic run_job(input bit ks, input logic [63:0] d, input int raise_at);
      int n;
      logic [63:0] r;
      logic [3:0]  nb;
      n = ks ? 4 : 16;
      if (ks) begin ks_req = 1'b1; ks_in = d[15:0]; end
      else begin st_req = 1'b1; st_in = d; end
      #1;
      chk(ks ? "ks_ack" : "st_ack", ks ? ks_ack : st_ack, 1);
      chk("other_ack", ks ? st_ack : ks_ack, 0);
      tick;
      if (ks) ks_req = 1'b0; else st_req = 1'b0;
      for (int c = 1; c <= n; c++) begin
         if (c == raise_at) begin
            if (ks) st_req = 1'b1; else ks_req = 1'b1;
         end
         #1;
         nb = d[4*(c-1) +: 4];
         chk("sbox_in", sbox_in, nb);
         chk("busy_run", busy, 1);
         chk("acks_run", {st_ack, ks_ack}, 0);
         chk("dones_run", {st_done, ks_done}, 0);
         tick;
      end
      r = sub_word(d, n);
      if (ks) exp_ks = r[15:0]; else exp_st = r;
      #1;
      chk(ks ? "ks_done" : "st_done", ks ? ks_done : st_done, 1);
      chk("other_done", ks ? st_done : ks_done, 0);
      chk("st_out", st_out, exp_st);
      chk("ks_out", ks_out, exp_ks);
      chk("sbox_in_done", sbox_in, 0);
      chk("acks_done", {st_ack, ks_ack}, 0);
      tick;
      chk("busy_idle", busy, 0);
      chk("dones_idle", {st_done, ks_done}, 0);
   endtask

   initial begin
      logic [63:0] d;
      rst = 1'b1; st_req = 1'b0; ks_req = 1'b0; st_in = '0; ks_in = '0;
      tick; tick;
      rst = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_acks", {st_ack, ks_ack}, 0);
      chk("rst_dones", {st_done, ks_done}, 0);
      chk("rst_st_out", st_out, 0);
      chk("rst_ks_out", ks_out, 0);
      chk("rst_sbox_in", sbox_in, 0);
      tick;

      run_job(1'b0, 64'h0123456789ABCDEF, 0);
      chk("single_st", st_out, 64'hFEDCBA9876543210);
      chk("single_st_ks", ks_out, 16'h0000);
      run_job(1'b1, 64'h1234, 0);
      chk("single_ks", ks_out, 16'hEDCB);

      // Reset restores last_srv=ST, so KS wins the first tie.
      rst = 1'b1; tick; rst = 1'b0; exp_st = '0; exp_ks = '0;
      st_req = 1'b1; st_in = 64'hA5A5_0F0F_1234_5678;
      run_job(1'b1, 64'h9C3E, 0);
      run_job(1'b0, 64'hA5A5_0F0F_1234_5678, 0);
      // Last grant was ST: a tie now goes to KS.
      st_req = 1'b1; st_in = 64'h1111_2222_3333_4444;
      run_job(1'b1, 64'h0F1E, 0);
      run_job(1'b0, 64'h1111_2222_3333_4444, 0);
      // After a lone KS job, a tie goes to ST.
      run_job(1'b1, 64'h7777, 0);
      ks_req = 1'b1; ks_in = 16'hBEEF;
      run_job(1'b0, 64'hDEAD_BEEF_CAFE_F00D, 0);
      run_job(1'b1, 64'hBEEF, 0);

      // KS request raised in cycle 3 of a state job waits until the next IDLE.
      ks_in = 16'h4C2A;
      run_job(1'b0, 64'h0011_2233_4455_6677, 3);
      run_job(1'b1, 64'h4C2A, 0);

      // Reset mid-job: cycle 8 of a state job.
      st_req = 1'b1; st_in = 64'h8899_AABB_CCDD_EEFF;
      tick;
      st_req = 1'b0;
      for (int c = 1; c < 8; c++) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      exp_st = '0; exp_ks = '0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_st_out", st_out, 0);
      chk("midrst_ks_out", ks_out, 0);
      chk("midrst_sbox_in", sbox_in, 0);
      for (int c = 0; c < 12; c++) begin
         tick;
         chk("midrst_no_done", {st_done, ks_done}, 0);
      end
      run_job(1'b0, 64'h8899_AABB_CCDD_EEFF, 0);

      // Randomized jobs, one requester at a time.
      for (int j = 0; j < 20; j++) begin
         d = {$urandom, $urandom};
         if ($urandom_range(1, 0) == 1) run_job(1'b1, {48'h0, d[15:0]}, 0);
         else run_job(1'b0, d, 0);
      end

      // Full S-box table: every nibble of each state job equals S(v).
      use_tbl = 1'b1;
      for (int v = 0; v < 16; v++) begin
         d = {16{4'(v)}};
         run_job(1'b0, d, 0);
         chk("table_st", st_out, {16{tbl[v]}});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
